game_round_ctrl: RTL and testbench
==================================

Name: game_round_ctrl

Overview:
- Round sequencer for the 4-player gravity-runner game.
- Sits between the new-game button, the line generators and the player generators.
- Latches the player roster at round start and runs a countdown with blank lines, then a run phase with random lines.
- Detects player deaths and declares a winner or a draw; freezes the playfield until the next new-game press.

Parameters:
- WAIT_START, 3000, countdown length in tick_i strobes before random lines begin.
- DEATH_TOP, 0, player y-location at or below which the player is dead.
- DEATH_BOTTOM, 440, player y-location at or above which the player is dead (window height minus player height).
- TICK_W, 16, width of the countdown and score counters.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous reset, active-low.
- new_game_i  input  1  raw new-game button level, asynchronous to clk_i.
- tick_i  input  1  single-cycle game-tick strobe in clk_i domain (line scroll rate).
- player_en_i  input  4  player enable switches, raw level.
- player_loc_i  input  36  packed y-locations, player n at [9n+8:9n].
- state_o  output  2  0=IDLE, 1=COUNTDOWN, 2=RUN, 3=OVER.
- line_type_o  output  1  0=solid lines, 1=random gaps; drives line generators.
- run_o  output  1  high in COUNTDOWN and RUN; gates line scroll and player motion.
- alive_o  output  4  per-player alive mask.
- winner_valid_o  output  1  high in OVER.
- winner_o  output  4  one-hot winner; 0 = draw.
- score_o  output  64  packed per-player survival counts, player n at [16n+15:16n].

Behaviour:
- Reset (rst_i=0, async): state IDLE, line_type_o=0, run_o=0, alive_o=0, winner_valid_o=0, winner_o=0, score_o=0, countdown=0.
- new_game_i: 2-flop synchroniser plus rising-edge detect → one-cycle pulse `ng`. A held button produces exactly one pulse.
- player_en_i: 2-flop synchronised; sampled only on `ng`.
- Outputs are registered. Transitions take effect the cycle after the causing event.
- IDLE:
  - On `ng` with enabled mask ≠ 0: roster←en, alive_o←en, scores←0, countdown←0, go to COUNTDOWN.
  - `ng` with mask = 0 is ignored.
- COUNTDOWN:
  - line_type_o=0, run_o=1. Countdown increments on tick_i.
  - When countdown == WAIT_START-1 and tick_i is high, go to RUN.
  - Deaths are not evaluated.
- RUN:
  - line_type_o=1, run_o=1.
  - On each tick_i, every alive player whose loc ≤ DEATH_TOP or loc ≥ DEATH_BOTTOM has its alive bit cleared. Multiple deaths in the same tick are all applied.
  - The end condition is evaluated on the post-update alive mask in the same cycle:
    - roster popcount ≥ 2: end when alive popcount ≤ 1.
    - roster popcount = 1: end when alive popcount = 0.
  - On end: go to OVER with winner_o = post-update alive mask (one-hot, or 0 for a draw or a solo death).
- OVER:
  - run_o=0, winner_valid_o=1. line_type_o holds 1; alive_o, winner_o and score_o hold.
  - On `ng`, same action as IDLE (restart). With an empty roster, go to IDLE and clear winner_o and winner_valid_o.
- `ng` during COUNTDOWN or RUN aborts and restarts the round, with the same action as from IDLE, roster re-latched. Empty roster → IDLE.
- tick_i outside COUNTDOWN or RUN has no effect. The countdown counter wraps only via reload.
- Disabled players (roster bit 0) are never alive, never scored, never winners. Their player_loc_i is ignored.

Optional Feature:
- Macro: GAME_ROUND_SCORE_EN.
- Defined: in RUN, each tick_i increments score[n] for every player still alive before that tick's death update. Counters saturate at 16'hFFFF and clear on round (re)start.
- Undefined: score_o is tied to 0 and no counters are synthesised. All other behaviour is identical.

Decomposition:
- Shared package game_pkg holds:
  - state encoding constants ST_IDLE..ST_OVER.
  - NUM_PLAYERS=4, LOC_W=9, window/player geometry constants that DEATH_BOTTOM is derived from.
- One sub-module: btn_sync_edge (2-flop synchroniser plus rising-edge pulse, async active-low reset). It is instantiated for new_game_i. The player_en_i synchroniser is plain flops.

Test Plan:
- Reset: rst_i low mid-RUN → all outputs at reset values within the same cycle; after release, state_o=0.
- Start and countdown:
  - Stimulus: en=4'b1011, press new_game, WAIT_START=4.
  - Required: state_o 0→1, alive_o=1011, line_type_o=0.
  - After 4 ticks: state_o=2, line_type_o=1.
  - A held button produces no second restart.
- Winner:
  - Stimulus: in RUN, set loc0=0 on tick, then loc3=445 on a later tick.
  - Required: alive_o 1011→1010→0010, state_o=3, winner_o=0010, winner_valid_o=1, run_o=0.
- Simultaneous death (draw):
  - Stimulus: en=0011, both locs=440 on the same tick.
  - Required: state_o=3, winner_o=0000.
  - With GAME_ROUND_SCORE_EN and 5 prior safe ticks: scores=6 each.
- Edge cases:
  - Stimulus: press new_game with en=0 → stays IDLE.
  - Required: press during RUN with en=0100 → COUNTDOWN, alive_o=0100, scores=0. Player 2 dying → OVER, winner_o=0.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the game round sequencer
//
// Purpose: state encoding, player/geometry constants and a popcount helper
//          used by game_round_ctrl.
// Ports:   none (package).
package game_pkg;

  localparam int NUM_PLAYERS = 4;
  localparam int LOC_W       = 9;

  // Playfield geometry; a player touching the bottom edge sits at
  // WINDOW_H - PLAYER_H.
  localparam int WINDOW_H         = 480;
  localparam int PLAYER_H         = 40;
  localparam int DEATH_BOTTOM_DEF = WINDOW_H - PLAYER_H;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RUN       = 2'd2,
    ST_OVER      = 2'd3
  } state_t;

  function automatic logic [2:0] popcount4(input logic [NUM_PLAYERS-1:0] m);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      c = c + 3'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchroniser with rising-edge pulse
//
// Purpose: brings an asynchronous button level into the clk_i domain and
//          emits a single-cycle pulse per rising edge; a held button
//          yields exactly one pulse.
// Ports:
//   clk_i    in   system clock
//   rst_i    in   asynchronous reset, active-low
//   din_i    in   raw asynchronous level
//   pulse_o  out  one-cycle pulse on synchronised rising edge
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic pulse_o
);

  logic s1, s2, s3;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse_o = s2 & ~s3;

endmodule

// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - round sequencer for the 4-player gravity-runner
//
// Purpose: latches the roster on new-game, runs a blank-line countdown,
//          then a random-line run phase, detects deaths and declares a
//          winner or draw, freezing until the next new-game press.
// Optional: GAME_ROUND_SCORE_EN enables per-player survival counters;
//           when undefined score_o is tied to zero.
// Ports:
//   clk_i           in   system clock
//   rst_i           in   asynchronous reset, active-low
//   new_game_i      in   raw new-game button level (asynchronous)
//   tick_i          in   single-cycle game-tick strobe
//   player_en_i     in   [3:0] raw player enable switches
//   player_loc_i    in   [35:0] packed y-locations, player n at [9n+8:9n]
//   state_o         out  [1:0] IDLE/COUNTDOWN/RUN/OVER
//   line_type_o     out  0 solid lines, 1 random gaps
//   run_o           out  high in COUNTDOWN and RUN
//   alive_o         out  [3:0] per-player alive mask
//   winner_valid_o  out  high in OVER
//   winner_o        out  [3:0] one-hot winner, 0 = draw
//   score_o         out  [63:0] packed survival counts, player n at [16n+15:16n]
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int WAIT_START   = 3000,
  parameter int DEATH_TOP    = 0,
  parameter int DEATH_BOTTOM = DEATH_BOTTOM_DEF,
  parameter int TICK_W       = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          new_game_i,
  input  logic                          tick_i,
  input  logic [NUM_PLAYERS-1:0]        player_en_i,
  input  logic [NUM_PLAYERS*LOC_W-1:0]  player_loc_i,
  output logic [1:0]                    state_o,
  output logic                          line_type_o,
  output logic                          run_o,
  output logic [NUM_PLAYERS-1:0]        alive_o,
  output logic                          winner_valid_o,
  output logic [NUM_PLAYERS-1:0]        winner_o,
  output logic [NUM_PLAYERS*TICK_W-1:0] score_o
);

  localparam logic [LOC_W-1:0]  DT      = LOC_W'(DEATH_TOP);
  localparam logic [LOC_W-1:0]  DB      = LOC_W'(DEATH_BOTTOM);
  localparam logic [TICK_W-1:0] WS_LAST = TICK_W'(WAIT_START - 1);

  logic ng;

  btn_sync_edge u_ng_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .din_i   (new_game_i),
    .pulse_o (ng)
  );

  logic [NUM_PLAYERS-1:0] en_s1, en_s2;

  state_t                 state_q, state_d;
  logic                   line_type_q, line_type_d;
  logic                   run_q, valid_q;
  logic [NUM_PLAYERS-1:0] alive_q, alive_d;
  logic [NUM_PLAYERS-1:0] winner_q, winner_d;
  logic [NUM_PLAYERS-1:0] roster_q, roster_d;
  logic [TICK_W-1:0]      cnt_q, cnt_d;

  logic [NUM_PLAYERS-1:0] dead;
  logic [NUM_PLAYERS-1:0] alive_post;
  logic                   round_end;

  always_comb begin
    dead = '0;
    for (int n = 0; n < NUM_PLAYERS; n++) begin
      dead[n] = (player_loc_i[n*LOC_W +: LOC_W] <= DT) ||
                (player_loc_i[n*LOC_W +: LOC_W] >= DB);
    end
  end

  // End condition uses the mask after this tick's deaths; a solo round
  // only ends when its single player dies.
  always_comb begin
    alive_post = alive_q & ~dead;
    if (popcount4(roster_q) >= 3'd2) begin
      round_end = (popcount4(alive_post) <= 3'd1);
    end else begin
      round_end = (popcount4(alive_post) == 3'd0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      en_s1 <= '0;
      en_s2 <= '0;
    end else begin
      en_s1 <= player_en_i;
      en_s2 <= en_s1;
    end
  end

  always_comb begin
    state_d     = state_q;
    line_type_d = line_type_q;
    alive_d     = alive_q;
    winner_d    = winner_q;
    roster_d    = roster_q;
    cnt_d       = cnt_q;
    if (ng && en_s2 != '0) begin
      state_d     = ST_COUNTDOWN;
      line_type_d = 1'b0;
      roster_d    = en_s2;
      alive_d     = en_s2;
      winner_d    = '0;
      cnt_d       = '0;
    end else if (ng && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      line_type_d = 1'b0;
      roster_d    = '0;
      alive_d     = '0;
      winner_d    = '0;
    end else begin
      case (state_q)
        ST_COUNTDOWN: begin
          if (tick_i) begin
            if (cnt_q == WS_LAST) begin
              state_d     = ST_RUN;
              line_type_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (tick_i) begin
            alive_d = alive_post;
            if (round_end) begin
              state_d  = ST_OVER;
              winner_d = alive_post;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      line_type_q <= 1'b0;
      run_q       <= 1'b0;
      valid_q     <= 1'b0;
      alive_q     <= '0;
      winner_q    <= '0;
      roster_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      line_type_q <= line_type_d;
      run_q       <= (state_d == ST_COUNTDOWN) || (state_d == ST_RUN);
      valid_q     <= (state_d == ST_OVER);
      alive_q     <= alive_d;
      winner_q    <= winner_d;
      roster_q    <= roster_d;
      cnt_q       <= cnt_d;
    end
  end

  assign state_o        = state_q;
  assign line_type_o    = line_type_q;
  assign run_o          = run_q;
  assign alive_o        = alive_q;
  assign winner_valid_o = valid_q;
  assign winner_o       = winner_q;

`ifdef GAME_ROUND_SCORE_EN
  logic [TICK_W-1:0] score_q [NUM_PLAYERS];
  logic              start;

  assign start = ng && (en_s2 != '0);

  // Counts players alive before this tick's death update, so a player
  // dying on a tick is still credited for it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int n = 0; n < NUM_PLAYERS; n++) score_q[n] <= '0;
    end else if (start) begin
      for (int n = 0; n < NUM_PLAYERS; n++) score_q[n] <= '0;
    end else if (!ng && state_q == ST_RUN && tick_i) begin
      for (int n = 0; n < NUM_PLAYERS; n++) begin
        if (alive_q[n] && score_q[n] != '1) score_q[n] <= score_q[n] + 1'b1;
      end
    end
  end

  always_comb begin
    score_o = '0;
    for (int n = 0; n < NUM_PLAYERS; n++) begin
      score_o[n*TICK_W +: TICK_W] = score_q[n];
    end
  end
`else
  assign score_o = '0;
`endif

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - directed self-checking bench for game_round_ctrl
module tb_game_round_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        new_game_i;
  logic        tick_i;
  logic [3:0]  player_en_i;
  logic [35:0] player_loc_i;
  logic [1:0]  state_o;
  logic        line_type_o;
  logic        run_o;
  logic [3:0]  alive_o;
  logic        winner_valid_o;
  logic [3:0]  winner_o;
  logic [63:0] score_o;

  int checks = 0;
  int errors = 0;

  game_round_ctrl #(
    .WAIT_START   (4),
    .DEATH_TOP    (0),
    .DEATH_BOTTOM (440),
    .TICK_W       (16)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .new_game_i     (new_game_i),
    .tick_i         (tick_i),
    .player_en_i    (player_en_i),
    .player_loc_i   (player_loc_i),
    .state_o        (state_o),
    .line_type_o    (line_type_o),
    .run_o          (run_o),
    .alive_o        (alive_o),
    .winner_valid_o (winner_valid_o),
    .winner_o       (winner_o),
    .score_o        (score_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_tick();
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic press();
    new_game_i = 1'b1;
    repeat (3) step();
    new_game_i = 1'b0;
    repeat (3) step();
  endtask

  task automatic set_loc(input int n, input logic [8:0] v);
    player_loc_i[n*9 +: 9] = v;
  endtask

  task automatic test_reset();
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
    checks++;
    if ({line_type_o, run_o, alive_o, winner_valid_o, winner_o} !== 11'd0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {line_type_o, run_o, alive_o, winner_valid_o, winner_o});
    end
    checks++;
    if (score_o !== 64'd0) begin errors++; $display("FAIL reset_score got %h want 0", score_o); end
  endtask

  task automatic test_start_countdown();
    player_en_i = 4'b1011;
    new_game_i = 1'b1;
    repeat (3) step();
    checks++;
    if (state_o !== 2'd1) begin errors++; $display("FAIL start_state got %0d want 1", state_o); end
    checks++;
    if (alive_o !== 4'b1011) begin errors++; $display("FAIL start_alive got %b want 1011", alive_o); end
    checks++;
    if (line_type_o !== 1'b0 || run_o !== 1'b1) begin
      errors++; $display("FAIL start_lt_run got %b%b want 01", line_type_o, run_o);
    end
    set_loc(0, 9'd0);
    do_ticks(3);
    checks++;
    if (state_o !== 2'd1 || alive_o !== 4'b1011) begin
      errors++; $display("FAIL countdown_nodeath got state %0d alive %b want 1 1011", state_o, alive_o);
    end
    set_loc(0, 9'd200);
    do_tick();
    checks++;
    if (state_o !== 2'd2 || line_type_o !== 1'b1) begin
      errors++; $display("FAIL to_run got state %0d lt %b want 2 1", state_o, line_type_o);
    end
    repeat (5) step();
    checks++;
    if (state_o !== 2'd2) begin errors++; $display("FAIL held_button got state %0d want 2", state_o); end
    new_game_i = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_winner();
    set_loc(0, 9'd0);
    do_tick();
    checks++;
    if (alive_o !== 4'b1010 || state_o !== 2'd2) begin
      errors++; $display("FAIL first_death got alive %b state %0d want 1010 2", alive_o, state_o);
    end
    set_loc(3, 9'd445);
    do_tick();
    checks++;
    if (alive_o !== 4'b0010 || state_o !== 2'd3) begin
      errors++; $display("FAIL second_death got alive %b state %0d want 0010 3", alive_o, state_o);
    end
    checks++;
    if (winner_o !== 4'b0010 || winner_valid_o !== 1'b1 || run_o !== 1'b0 || line_type_o !== 1'b1) begin
      errors++; $display("FAIL winner got w %b v %b run %b lt %b want 0010 1 0 1",
                         winner_o, winner_valid_o, run_o, line_type_o);
    end
    set_loc(1, 9'd0);
    do_tick();
    checks++;
    if (alive_o !== 4'b0010 || winner_o !== 4'b0010 || state_o !== 2'd3) begin
      errors++; $display("FAIL over_hold got alive %b w %b state %0d want 0010 0010 3", alive_o, winner_o, state_o);
    end
    player_loc_i = {4{9'd200}};
  endtask

  task automatic test_draw();
    player_en_i = 4'b0011;
    press();
    checks++;
    if (state_o !== 2'd1 || alive_o !== 4'b0011 || winner_valid_o !== 1'b0) begin
      errors++; $display("FAIL restart_over got state %0d alive %b v %b want 1 0011 0", state_o, alive_o, winner_valid_o);
    end
    do_ticks(4);
    set_loc(0, 9'd1);
    set_loc(1, 9'd439);
    do_ticks(5);
    checks++;
    if (state_o !== 2'd2 || alive_o !== 4'b0011) begin
      errors++; $display("FAIL boundary_safe got state %0d alive %b want 2 0011", state_o, alive_o);
    end
    set_loc(0, 9'd440);
    set_loc(1, 9'd440);
    do_tick();
    checks++;
    if (state_o !== 2'd3 || winner_o !== 4'b0000 || winner_valid_o !== 1'b1) begin
      errors++; $display("FAIL draw got state %0d w %b v %b want 3 0000 1", state_o, winner_o, winner_valid_o);
    end
`ifdef GAME_ROUND_SCORE_EN
    checks++;
    if (score_o !== 64'h0000_0000_0006_0006) begin
      errors++; $display("FAIL draw_score got %h want 0000000000060006", score_o);
    end
`else
    checks++;
    if (score_o !== 64'd0) begin errors++; $display("FAIL draw_score got %h want 0", score_o); end
`endif
    player_loc_i = {4{9'd200}};
  endtask

  task automatic test_edge();
    player_en_i = 4'b0000;
    press();
    checks++;
    if (state_o !== 2'd0 || winner_valid_o !== 1'b0 || winner_o !== 4'b0000) begin
      errors++; $display("FAIL over_to_idle got state %0d v %b w %b want 0 0 0000", state_o, winner_valid_o, winner_o);
    end
    press();
    checks++;
    if (state_o !== 2'd0 || run_o !== 1'b0) begin
      errors++; $display("FAIL idle_empty got state %0d run %b want 0 0", state_o, run_o);
    end
    player_en_i = 4'b0100;
    press();
    do_ticks(4);
    do_ticks(2);
    checks++;
    if (state_o !== 2'd2) begin errors++; $display("FAIL solo_run got state %0d want 2", state_o); end
    press();
    checks++;
    if (state_o !== 2'd1 || alive_o !== 4'b0100 || score_o !== 64'd0) begin
      errors++; $display("FAIL abort_restart got state %0d alive %b score %h want 1 0100 0", state_o, alive_o, score_o);
    end
    do_ticks(4);
    set_loc(2, 9'd0);
    do_tick();
    checks++;
    if (state_o !== 2'd3 || winner_o !== 4'b0000 || alive_o !== 4'b0000) begin
      errors++; $display("FAIL solo_death got state %0d w %b alive %b want 3 0000 0000", state_o, winner_o, alive_o);
    end
    player_loc_i = {4{9'd200}};
  endtask

  task automatic test_reset_midrun();
    player_en_i = 4'b1111;
    press();
    do_ticks(4);
    do_ticks(1);
    checks++;
    if (state_o !== 2'd2) begin errors++; $display("FAIL pre_reset got state %0d want 2", state_o); end
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (state_o !== 2'd0 || {line_type_o, run_o, alive_o, winner_valid_o, winner_o} !== 11'd0 || score_o !== 64'd0) begin
      errors++; $display("FAIL async_reset got state %0d outs %b score %h want 0 0 0",
                         state_o, {line_type_o, run_o, alive_o, winner_valid_o, winner_o}, score_o);
    end
    step();
    rst_i = 1'b1;
    step();
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("FAIL post_reset got state %0d want 0", state_o); end
  endtask

  initial begin
    rst_i        = 1'b0;
    new_game_i   = 1'b0;
    tick_i       = 1'b0;
    player_en_i  = 4'b0000;
    player_loc_i = {4{9'd200}};
    repeat (2) step();
    test_reset();
    rst_i = 1'b1;
    step();
    test_start_countdown();
    test_winner();
    test_draw();
    test_edge();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
